max_block_sequencer: RTL and testbench
======================================

// Module: max_block_sequencer
// PURPOSE
//   Finds the maximum of a block of N unsigned W-bit samples using one shared combinational comparator.
//   Samples arrive over a valid/ready stream; the block reports the maximum and the index of its first occurrence.
//   Sits between a sample source and a result consumer and sequences the comparator one sample per cycle.
// PARAMETERS
//   W   4  sample width, in bits (unsigned)
//   N   8  samples per block, N >= 1
//   IW  derived localparam = max(1, clog2(N)); width of out_idx and of the internal counter
// PORTS
//   clk        in   1   single clock; all state updates on the rising edge
//   rst        in   1   reset, synchronous and active-high
//   start      in   1   pulse that begins a new block; honoured only in IDLE
//   in_valid   in   1   in_data is valid this cycle
//   in_data    in   W   sample, unsigned
//   in_ready   out  1   block accepts a sample this cycle; a sample transfers when in_valid && in_ready
//   out_valid  out  1   result is valid
//   out_max    out  W   maximum of the block
//   out_idx    out  IW  index (0..N-1) of the first sample equal to out_max
//   out_ready  in   1   consumer takes the result when out_valid && out_ready
//   busy       out  1   high in ACCUM and DONE
// BEHAVIOUR
//   - Reset: state=IDLE; in_ready=0; out_valid=0; out_max=0; out_idx=0; busy=0; cnt=0; run_max=0; run_idx=0.
//     rst wins over every other input. Reset mid-block discards all partial data at the next edge.
//   - FSM has three states: IDLE, ACCUM and DONE. All outputs are registered or decoded from the state only.
//   - IDLE: in_ready=0 and out_valid=0. On start=1, go to ACCUM next cycle with cnt=0.
//   - ACCUM: in_ready=1 and busy=1. A sample transfers on each cycle with in_valid=1.
//     Cycles with in_valid=0 are allowed and change nothing.
//     - Sample at cnt=0: run_max <= in_data and run_idx <= 0, with no compare.
//     - Sample at cnt>0: the comparator computes gt = (in_data > run_max), unsigned and strict.
//       If gt=1, run_max <= in_data and run_idx <= cnt. A tie keeps the earlier index.
//     - cnt increments on each transfer.
//     - On the transfer with cnt==N-1: go to DONE. in_ready=0 from the next cycle.
//       With N=1, the first transfer goes directly to DONE.
//   - DONE: out_valid=1, out_max=run_max and out_idx=run_idx; these stay stable until the handshake.
//     in_ready=0, so in_valid is ignored.
//     On out_valid && out_ready: go to IDLE next cycle; out_valid=0 and busy=0.
//     out_max and out_idx hold their last values.
//   - Latency: out_valid rises exactly 1 cycle after the edge that accepts the Nth sample.
//     Minimum block time is 1 (start) + N (samples) + 1 (result) cycles.
//   - start is ignored in ACCUM and in DONE.
//     start in the same cycle as the DONE handshake is also ignored; the source must re-pulse start in IDLE.
//   - No sample buffering: a sample offered while in_ready=0 is not captured.
//   - cnt never wraps: it is cleared on entry to ACCUM and stops at N-1.
// STRUCTURE
//   - Shared include max_defs.vh holds:
//     - the state encodings ST_IDLE=2'd0, ST_ACCUM=2'd1 and ST_DONE=2'd2;
//     - the default W and N.
//   - One sub-module, max_cmp #(W): combinational.
//     Inputs a and b; outputs gt = (b > a) and y = gt ? b : a.
//     It is instantiated once, with a=run_max and b=in_data.
//   - The top level holds the FSM, cnt, run_max and run_idx.
// TESTING
//   1. N=8, start, then samples 1011,1001,0101,1010,0111,0001,1101,0100 back-to-back
//      -> out_max=1101 and out_idx=6; out_valid rises 1 cycle after the 8th accept.
//   2. N=8, all eight samples are 1010 -> out_max=1010, out_idx=0 (a tie keeps the first index).
//   3. Samples with in_valid gaps of 0-3 cycles, and out_ready held low 5 cycles in DONE
//      -> result unchanged from test 1; out_valid, out_max and out_idx stay stable until out_ready=1.
//   4. rst asserted after 3 accepts -> next cycle in_ready=0, out_valid=0, busy=0.
//      Then a new block of eight 0000 samples -> out_max=0000, out_idx=0.
//   5. start pulsed in ACCUM and in DONE, including the DONE handshake cycle
//      -> no restart and no cnt change; the block returns to IDLE and needs a fresh start.
//   6. N=1, sample 0110 -> DONE after one accept; out_max=0110, out_idx=0.
//      Also: in_valid=1 in IDLE -> no transfer.

Source files
------------

// File: rtl/max_block_sequencer_pkg.sv
// Shared definitions for the max-of-block sequencer: state encodings, default
// sizing and the index-width helper.
package max_block_sequencer_pkg;

   localparam int DefaultW = 4;
   localparam int DefaultN = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   // Index/counter width; a single-sample block still needs one bit.
   function automatic int idxWidth(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/max_block_sequencer_cmp.sv
// Shared unsigned comparator: flags when b beats a and forwards the larger value.
module max_cmp #(
   parameter int W = 4
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         gt,
   output logic [W-1:0] y
);

   assign gt = (b > a);
   assign y  = gt ? b : a;

endmodule

// File: rtl/max_block_sequencer.sv
// Streams a block of N samples through one comparator, then presents the block
// maximum and the index of its first occurrence until the consumer takes it.
module max_block_sequencer
   import max_block_sequencer_pkg::*;
#(
   parameter  int W  = DefaultW,
   parameter  int N  = DefaultN,
   localparam int IW = idxWidth(N)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          in_valid,
   input  logic [W-1:0]  in_data,
   output logic          in_ready,
   output logic          out_valid,
   output logic [W-1:0]  out_max,
   output logic [IW-1:0] out_idx,
   input  logic          out_ready,
   output logic          busy
);

   localparam logic [IW-1:0] LastIdx = IW'(N - 1);

   state_e        state_q, state_d;
   logic [IW-1:0] cnt_q, cnt_d;
   logic [W-1:0]  runMax_q, runMax_d;
   logic [IW-1:0] runIdx_q, runIdx_d;
   logic [W-1:0]  outMax_q, outMax_d;
   logic [IW-1:0] outIdx_q, outIdx_d;

   logic          cmpGt;
   logic [W-1:0]  cmpY;
   logic [W-1:0]  newMax;
   logic [IW-1:0] newIdx;

   max_cmp #(.W(W)) u_cmp (
      .a  (runMax_q),
      .b  (in_data),
      .gt (cmpGt),
      .y  (cmpY)
   );

   // The first sample seeds the running maximum; later ones only win on a strict
   // greater-than, so ties keep the earlier index.
   always_comb begin
      newMax = runMax_q;
      newIdx = runIdx_q;
      if (cnt_q == '0) begin
         newMax = in_data;
         newIdx = '0;
      end else begin
         newMax = cmpY;
         if (cmpGt) begin
            newIdx = cnt_q;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      runMax_d = runMax_q;
      runIdx_d = runIdx_q;
      outMax_d = outMax_q;
      outIdx_d = outIdx_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_ACCUM;
               cnt_d   = '0;
            end
         end
         ST_ACCUM: begin
            if (in_valid) begin
               runMax_d = newMax;
               runIdx_d = newIdx;
               if (cnt_q == LastIdx) begin
                  state_d  = ST_DONE;
                  outMax_d = newMax;
                  outIdx_d = newIdx;
               end else begin
                  cnt_d = cnt_q + IW'(1);
               end
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         runMax_q <= '0;
         runIdx_q <= '0;
         outMax_q <= '0;
         outIdx_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         runMax_q <= runMax_d;
         runIdx_q <= runIdx_d;
         outMax_q <= outMax_d;
         outIdx_q <= outIdx_d;
      end
   end

   // The result lives in its own registers so it holds steady while a new block accumulates.
   assign in_ready  = (state_q == ST_ACCUM);
   assign out_valid = (state_q == ST_DONE);
   assign busy      = (state_q == ST_ACCUM) || (state_q == ST_DONE);
   assign out_max   = outMax_q;
   assign out_idx   = outIdx_q;

endmodule

// File: tb/tb_max_block_sequencer.sv
// Directed bench for max_block_sequencer: an N=8 and an N=1 instance checked
// every cycle against a block-level model, plus literal expectations.
module tb_max_block_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       start, inValid, outReady;
   logic [3:0] inData;
   logic       inReady, outValid, busy;
   logic [3:0] outMax;
   logic [2:0] outIdx;

   logic       start1, inValid1, outReady1;
   logic [3:0] inData1;
   logic       inReady1, outValid1, busy1;
   logic [3:0] outMax1;
   logic [0:0] outIdx1;

   int checks = 0;
   int errors = 0;
   bit checkEn = 0;

   int mPhase[2];
   int mCnt[2];
   int mMax[2];
   int mIdx[2];
   int mSamp[2][8];
   int mN[2] = '{8, 1};

   always #5 clk = ~clk;

   max_block_sequencer #(.W(4), .N(8)) dut8 (
      .clk(clk), .rst(rst), .start(start), .in_valid(inValid), .in_data(inData),
      .in_ready(inReady), .out_valid(outValid), .out_max(outMax), .out_idx(outIdx),
      .out_ready(outReady), .busy(busy)
   );

   max_block_sequencer #(.W(4), .N(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .in_valid(inValid1), .in_data(inData1),
      .in_ready(inReady1), .out_valid(outValid1), .out_max(outMax1), .out_idx(outIdx1),
      .out_ready(outReady1), .busy(busy1)
   );

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Block-level model: phase 0 = waiting for start, 1 = collecting, 2 = result held.
   task automatic modelStep(input int k, input bit r, input bit s, input bit v, input int d, input bit o);
      if (r) begin
         mPhase[k] = 0;
         mCnt[k]   = 0;
         mMax[k]   = 0;
         mIdx[k]   = 0;
      end else begin
         case (mPhase[k])
            0: if (s) begin
               mPhase[k] = 1;
               mCnt[k]   = 0;
            end
            1: if (v) begin
               mSamp[k][mCnt[k]] = d;
               mCnt[k]++;
               if (mCnt[k] == mN[k]) begin
                  mMax[k] = mSamp[k][0];
                  mIdx[k] = 0;
                  for (int i = 1; i < mN[k]; i++) begin
                     if (mSamp[k][i] > mMax[k]) begin
                        mMax[k] = mSamp[k][i];
                        mIdx[k] = i;
                     end
                  end
                  mPhase[k] = 2;
               end
            end
            default: if (o) mPhase[k] = 0;
         endcase
      end
   endtask

   always @(posedge clk) begin
      modelStep(0, rst, start, inValid, int'(inData), outReady);
      modelStep(1, rst, start1, inValid1, int'(inData1), outReady1);
   end

   always @(negedge clk) begin
      if (checkEn) begin
         checkOutput("n8_in_ready",  inReady,  32'(mPhase[0] == 1));
         checkOutput("n8_out_valid", outValid, 32'(mPhase[0] == 2));
         checkOutput("n8_busy",      busy,     32'(mPhase[0] != 0));
         checkOutput("n8_out_max",   outMax,   mMax[0]);
         checkOutput("n8_out_idx",   outIdx,   mIdx[0]);
         checkOutput("n1_in_ready",  inReady1,  32'(mPhase[1] == 1));
         checkOutput("n1_out_valid", outValid1, 32'(mPhase[1] == 2));
         checkOutput("n1_busy",      busy1,     32'(mPhase[1] != 0));
         checkOutput("n1_out_max",   outMax1,   mMax[1]);
         checkOutput("n1_out_idx",   outIdx1,   mIdx[1]);
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic applyStimulus(input bit s, input bit v, input logic [3:0] d, input bit o);
      start    = s;
      inValid  = v;
      inData   = d;
      outReady = o;
      tick();
   endtask

   logic [3:0] t1[8]   = '{4'hB, 4'h9, 4'h5, 4'hA, 4'h7, 4'h1, 4'hD, 4'h4};
   logic [3:0] t5[8]   = '{4'h2, 4'h8, 4'h3, 4'h8, 4'h1, 4'h6, 4'h8, 4'h0};
   int         gaps[8] = '{0, 1, 2, 3, 0, 3, 1, 2};

   initial begin
      rst = 1'b1;
      start = 0; inValid = 0; inData = '0; outReady = 0;
      start1 = 0; inValid1 = 0; inData1 = '0; outReady1 = 0;
      tick();
      tick();
      checkEn = 1;
      checkOutput("reset_out_max", outMax, 0);
      checkOutput("reset_busy", busy, 0);
      rst = 1'b0;
      tick();

      // Test 1: back-to-back block
      applyStimulus(1, 0, 4'h0, 0);
      for (int i = 0; i < 8; i++) begin
         applyStimulus(0, 1, t1[i], 0);
         if (i == 6) checkOutput("t1_not_early", outValid, 0);
      end
      checkOutput("t1_valid_latency", outValid, 1);
      checkOutput("t1_max", outMax, 4'hD);
      checkOutput("t1_idx", outIdx, 6);
      applyStimulus(0, 0, 4'h0, 1);
      checkOutput("t1_back_idle", busy, 0);

      // Test 2: all ties
      applyStimulus(1, 0, 4'h0, 0);
      for (int i = 0; i < 8; i++) applyStimulus(0, 1, 4'hA, 0);
      checkOutput("t2_max", outMax, 4'hA);
      checkOutput("t2_idx", outIdx, 0);
      applyStimulus(0, 0, 4'h0, 1);

      // Test 3: valid gaps and consumer back-pressure
      applyStimulus(1, 0, 4'h0, 0);
      for (int i = 0; i < 8; i++) begin
         for (int g = 0; g < gaps[i]; g++) applyStimulus(0, 0, 4'hF, 0);
         applyStimulus(0, 1, t1[i], 0);
      end
      for (int c = 0; c < 5; c++) begin
         checkOutput("t3_hold_valid", outValid, 1);
         checkOutput("t3_hold_max", outMax, 4'hD);
         checkOutput("t3_hold_idx", outIdx, 6);
         applyStimulus(0, 0, 4'h0, 0);
      end
      applyStimulus(0, 0, 4'h0, 1);
      checkOutput("t3_released", outValid, 0);

      // Test 4: reset mid-block, then an all-zero block
      applyStimulus(1, 0, 4'h0, 0);
      applyStimulus(0, 1, 4'hF, 0);
      applyStimulus(0, 1, 4'hE, 0);
      applyStimulus(0, 1, 4'hD, 0);
      rst = 1'b1;
      applyStimulus(1, 1, 4'hC, 1);
      rst = 1'b0;
      checkOutput("t4_rst_in_ready", inReady, 0);
      checkOutput("t4_rst_out_valid", outValid, 0);
      checkOutput("t4_rst_busy", busy, 0);
      checkOutput("t4_rst_out_max", outMax, 0);
      applyStimulus(1, 0, 4'h0, 0);
      for (int i = 0; i < 8; i++) applyStimulus(0, 1, 4'h0, 0);
      checkOutput("t4_valid", outValid, 1);
      checkOutput("t4_max", outMax, 4'h0);
      checkOutput("t4_idx", outIdx, 0);
      applyStimulus(0, 0, 4'h0, 1);

      // Test 5: start pulses outside IDLE are ignored
      applyStimulus(1, 0, 4'h0, 0);
      for (int i = 0; i < 8; i++) begin
         applyStimulus((i % 2) == 0, 1, t5[i], 0);
         if (i == 3) applyStimulus(1, 0, 4'hF, 0);
      end
      checkOutput("t5_max", outMax, 4'h8);
      checkOutput("t5_idx", outIdx, 1);
      applyStimulus(1, 0, 4'h0, 0);
      checkOutput("t5_done_start_ignored", outValid, 1);
      applyStimulus(1, 0, 4'h0, 1);
      checkOutput("t5_handshake_idle", busy, 0);
      checkOutput("t5_no_restart", inReady, 0);
      applyStimulus(0, 1, 4'h5, 0);
      checkOutput("t5_idle_no_transfer", busy, 0);
      checkOutput("t5_result_held", outMax, 4'h8);

      // Test 6: single-sample block, with in_valid offered while idle
      inValid1 = 1; inData1 = 4'hF;
      tick();
      checkOutput("t6_idle_in_ready", inReady1, 0);
      checkOutput("t6_idle_out_valid", outValid1, 0);
      start1 = 1;
      tick();
      start1 = 0;
      checkOutput("t6_accum", inReady1, 1);
      checkOutput("t6_no_idle_capture", outValid1, 0);
      inData1 = 4'h6;
      tick();
      inValid1 = 0;
      checkOutput("t6_done", outValid1, 1);
      checkOutput("t6_max", outMax1, 4'h6);
      checkOutput("t6_idx", outIdx1, 0);
      outReady1 = 1;
      tick();
      outReady1 = 0;
      checkOutput("t6_back_idle", busy1, 0);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
